buffer_memory_controller: RTL

BUFFER_MEMORY_CONTROLLER -- requirements
Module: buffer_memory_controller

---
 rtl/buffer_memory_controller_pkg.sv | 13 +
 rtl/buffer_memory_controller_rr_arbiter.sv | 29 ++
 rtl/buffer_memory_controller.sv | 118 +++++++++++
 3 files changed

// File: rtl/buffer_memory_controller_pkg.sv
// Shared defaults and pointer helpers for the buffered multi-requester write controller.
package buffer_memory_controller_pkg;

    localparam int DEF_DATA_WIDTH = 40;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_NUM_REQ    = 4;

    // Advance a circular pointer, wrapping limit-1 back to 0 (limit need not be a power of two).
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned limit);
        return (ptr >= limit - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/buffer_memory_controller_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after rr_ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    input  logic                       enable,
    output logic [NUM_REQ-1:0]         gnt
);

    localparam int RR_W = $clog2(NUM_REQ);

    logic            found;
    logic [RR_W-1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = RR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (enable && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/buffer_memory_controller.sv
// Multi-requester FIFO buffer: round-robin write arbitration into a slot array, in-order readout.
module buffer_memory_controller
    import buffer_memory_controller_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int NUM_REQ    = DEF_NUM_REQ
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          full,
    output logic                          empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int RR_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] slot_data [DEPTH];
    logic [DEPTH-1:0]      slot_empty;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [RR_W-1:0]       rr_ptr;

    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] push_data;
    logic [RR_W-1:0]       grant_idx;
    logic [DEPTH-1:0]      wr_en;
    logic [DEPTH-1:0]      rd_clr;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Reset gates the arbiter so nothing is granted while state is being cleared.
    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arbiter (
        .req    (req),
        .rr_ptr (rr_ptr),
        .enable (!full && !reset),
        .gnt    (gnt)
    );

    assign push      = |gnt;
    assign out_valid = !slot_empty[rd_ptr];
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? slot_data[rd_ptr] : '0;

    always_comb begin
        push_data = '0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                push_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                grant_idx = RR_W'(i);
            end
        end
    end

    always_comb begin
        wr_en  = '0;
        rd_clr = '0;
        for (int j = 0; j < DEPTH; j++) begin
            wr_en[j]  = push && (wr_ptr == PTR_W'(j));
            rd_clr[j] = pop && (rd_ptr == PTR_W'(j));
        end
    end

    // Push and pop never target the same slot: they coincide only when empty or full.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < DEPTH; j++) begin
                slot_data[j] <= '0;
            end
            slot_empty <= '1;
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                if (wr_en[j]) begin
                    slot_data[j]  <= push_data;
                    slot_empty[j] <= 1'b0;
                end else if (rd_clr[j]) begin
                    slot_empty[j] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= PTR_W'(ptr_inc(32'(wr_ptr), DEPTH));
                rr_ptr <= RR_W'(ptr_inc(32'(grant_idx), NUM_REQ));
            end
            if (pop) begin
                rd_ptr <= PTR_W'(ptr_inc(32'(rd_ptr), DEPTH));
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule
